// File: rtl/btn_pulse_gen_if.sv
// Button conditioning bus: raw button and repeat enable in, clean pulse and
// debounced level out.
interface btn_pulse_gen_if;
   logic btn_raw;
   logic repeat_en;
   logic pulse;
   logic pressed;

   modport master (
      output btn_raw,
      output repeat_en,
      input  pulse,
      input  pressed
   );

   modport slave (
      input  btn_raw,
      input  repeat_en,
      output pulse,
      output pressed
   );
endinterface

// File: rtl/btn_pulse_gen.sv
// Turns a bouncing push-button into single-cycle count-enable pulses, with
// a 2-FF synchronizer, a debounce FSM and optional auto-repeat while held.
module btn_pulse_gen #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int REPEAT_DELAY    = 64,
   parameter int REPEAT_PERIOD   = 8
) (
   input logic          clk,
   input logic          rst,
   btn_pulse_gen_if.slave bus
);

   localparam int MAXP_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
   localparam int MAXP   = (MAXP_A > REPEAT_PERIOD) ? MAXP_A : REPEAT_PERIOD;
   localparam int CW     = $clog2(MAXP);

   localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] RD_LAST  = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] RP_LAST  = CW'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_RELEASE} state_t;
   typedef enum logic {PH_DELAY, PH_PERIOD} phase_t;

   logic          sync1;
   logic          btn_s;
   state_t        state,   state_n;
   logic [CW-1:0] deb_cnt, deb_n;
   logic [CW-1:0] rep_cnt, rep_n;
   phase_t        phase,   phase_n;
   logic          pulse_q, pulse_n;
   logic          pressed_q, pressed_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1     <= 1'b0;
         btn_s     <= 1'b0;
         state     <= IDLE;
         deb_cnt   <= '0;
         rep_cnt   <= '0;
         phase     <= PH_DELAY;
         pulse_q   <= 1'b0;
         pressed_q <= 1'b0;
      end else begin
         sync1     <= bus.btn_raw;
         btn_s     <= sync1;
         state     <= state_n;
         deb_cnt   <= deb_n;
         rep_cnt   <= rep_n;
         phase     <= phase_n;
         pulse_q   <= pulse_n;
         pressed_q <= pressed_n;
      end
   end

   // Timers only count up to their limit and are cleared whenever a state is entered.
   always_comb begin
      state_n   = state;
      deb_n     = deb_cnt;
      rep_n     = rep_cnt;
      phase_n   = phase;
      pulse_n   = 1'b0;
      pressed_n = pressed_q;
      case (state)
         IDLE: begin
            if (btn_s) begin
               state_n = DEB_PRESS;
               deb_n   = '0;
            end
         end
         DEB_PRESS: begin
            if (!btn_s) begin
               state_n = IDLE;
               deb_n   = '0;
            end else if (deb_cnt == DEB_LAST) begin
               state_n   = HELD;
               deb_n     = '0;
               pulse_n   = 1'b1;
               pressed_n = 1'b1;
               rep_n     = '0;
               phase_n   = PH_DELAY;
            end else begin
               deb_n = deb_cnt + CW'(1);
            end
         end
         HELD: begin
            if (!btn_s) begin
               state_n = DEB_RELEASE;
               deb_n   = '0;
            end else if (!bus.repeat_en) begin
               rep_n   = '0;
               phase_n = PH_DELAY;
            end else if ((phase == PH_DELAY  && rep_cnt == RD_LAST) ||
                         (phase == PH_PERIOD && rep_cnt == RP_LAST)) begin
               pulse_n = 1'b1;
               rep_n   = '0;
               phase_n = PH_PERIOD;
            end else begin
               rep_n = rep_cnt + CW'(1);
            end
         end
         DEB_RELEASE: begin
            // A release bounce returns to HELD silently and restarts the repeat delay.
            if (btn_s) begin
               state_n = HELD;
               deb_n   = '0;
               rep_n   = '0;
               phase_n = PH_DELAY;
            end else if (deb_cnt == DEB_LAST) begin
               state_n   = IDLE;
               deb_n     = '0;
               pressed_n = 1'b0;
            end else begin
               deb_n = deb_cnt + CW'(1);
            end
         end
         default: begin
            state_n = IDLE;
            deb_n   = '0;
            rep_n   = '0;
            phase_n = PH_DELAY;
         end
      endcase
   end

   assign bus.pulse   = pulse_q;
   assign bus.pressed = pressed_q;

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Directed and randomized bench for btn_pulse_gen, checked every cycle against
// a run-length model of the button behaviour.
module tb_btn_pulse_gen;

   localparam int D  = 4;
   localparam int RD = 8;
   localparam int RP = 3;

   logic clk = 1'b0;
   logic rst;
   btn_pulse_gen_if bus ();

   btn_pulse_gen #(
      .DEBOUNCE_CYCLES(D),
      .REPEAT_DELAY   (RD),
      .REPEAT_PERIOD  (RP)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   bit m_s1, m_s2, m_prev, m_pressed, m_pulse, m_delay;
   int run1, run0, streak;

   int npulse, firstp, fallp, ctr, wraps;
   bit prev_pressed;

   // Model: a press is accepted after D+1 consecutive high synchronized samples,
   // a release after D+1 low ones; repeats count qualifying held edges.
   task automatic modelEdge();
      bit b;
      b = m_s2;
      if (rst) begin
         m_s1 = 0; m_s2 = 0; m_prev = 0; m_pressed = 0; m_pulse = 0; m_delay = 1;
         run1 = 0; run0 = 0; streak = 0;
         return;
      end
      m_pulse = 0;
      if (!m_pressed) begin
         run1 = b ? run1 + 1 : 0;
         if (run1 == D + 1) begin
            m_pressed = 1; m_pulse = 1; streak = 0; m_delay = 1; run0 = 0;
         end
      end else if (!b) begin
         run0++;
         if (run0 == D + 1) begin
            m_pressed = 0; run1 = 0;
         end
      end else begin
         run0 = 0;
         if (!m_prev || !bus.repeat_en) begin
            streak = 0; m_delay = 1;
         end else begin
            streak++;
            if (streak == (m_delay ? RD : RP)) begin
               m_pulse = 1; streak = 0; m_delay = 0;
            end
         end
      end
      m_prev = b;
      m_s2   = m_s1;
      m_s1   = bus.btn_raw;
   endtask

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input bit raw, input bit en, input bit r, input string tag);
      bus.btn_raw   = raw;
      bus.repeat_en = en;
      rst           = r;
      @(posedge clk);
      modelEdge();
      #1;
      checkOutput({tag, "_pulse"},   int'(bus.pulse),   int'(m_pulse));
      checkOutput({tag, "_pressed"}, int'(bus.pressed), int'(m_pressed));
   endtask

   initial begin
      bit raw, en, r;
      bus.btn_raw = 0; bus.repeat_en = 0; rst = 1;
      m_delay = 1;

      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, "reset");

      // Clean press, no repeat
      npulse = 0; firstp = -1; fallp = -1; prev_pressed = 0;
      for (int i = 0; i < 32; i++) begin
         applyStimulus(i < 20, 0, 0, "clean");
         if (bus.pulse === 1'b1) begin npulse++; firstp = i; end
         if (prev_pressed && bus.pressed === 1'b0) fallp = i;
         prev_pressed = bus.pressed;
      end
      checkOutput("clean_npulse", npulse, 1);
      checkOutput("clean_first_edge", firstp, 6);
      checkOutput("clean_release_edge", fallp, 26);

      // Short press glitch
      npulse = 0;
      for (int i = 0; i < 13; i++) begin
         applyStimulus(i < 3, 0, 0, "glitch");
         if (bus.pulse === 1'b1) npulse++;
      end
      checkOutput("glitch_npulse", npulse, 0);

      // Auto-repeat hold
      npulse = 0;
      for (int i = 0; i < 40; i++) begin
         applyStimulus(i < 30, 1, 0, "repeat");
         if (bus.pulse === 1'b1) npulse++;
      end
      checkOutput("repeat_npulse", npulse, 7);

      // Release bounce inside a held press
      for (int i = 0; i < 40; i++)
         applyStimulus(!(i == 12 || i == 13 || i >= 28), 1, 0, "relbounce");

      // Reset mid-debounce and mid-held with button held
      for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, "rst_a");
      applyStimulus(1, 0, 1, "rst_a_edge");
      firstp = -1;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1, 0, 0, "rst_b");
         if (bus.pulse === 1'b1 && firstp < 0) firstp = i;
      end
      checkOutput("rst_repulse_edge", firstp, 6);
      applyStimulus(1, 1, 1, "rst_c_edge");
      for (int i = 0; i < 16; i++) applyStimulus(i < 10, 1, 0, "rst_d");

      // Randomized traffic
      raw = 0; en = 0;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 9) == 0)  raw = ~raw;
         if ($urandom_range(0, 39) == 0) en  = ~en;
         r = ($urandom_range(0, 149) == 0);
         applyStimulus(raw, en, r, "random");
      end
      for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, "settle");

      // 32 bouncy presses feeding a mod-32 counter
      npulse = 0; ctr = 0; wraps = 0;
      for (int p = 0; p < 32; p++) begin
         for (int i = 0; i < 27; i++) begin
            raw = (i < 4) ? ((i % 2) == 0) : (i < 14) ? 1'b1 : (i == 15);
            applyStimulus(raw, 0, 0, "system");
            if (bus.pulse === 1'b1) begin
               npulse++;
               ctr = (ctr + 1) % 32;
               if (ctr == 0) wraps++;
            end
         end
      end
      checkOutput("system_npulse", npulse, 32);
      checkOutput("system_counter", ctr, 0);
      checkOutput("system_wraps", wraps, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
